memctrl_arb: RTL and testbench

//  Parametrised next-generation RV32I memory controller: arbitrates instruction-fetch and data (load/store)

---
 rtl/memctrl_pkg.sv | 24 ++
 rtl/memctrl_rr_arb.sv | 37 +++
 rtl/memctrl_arb.sv | 168 ++++++++++++++++
 tb/tb_memctrl_arb.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// Shared types for the memctrl_arb memory controller: FSM state encoding and
// bus ownership.
package memctrl_pkg;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    READ_REQ  = 3'd2,
    WRITE_REQ = 3'd3,
    READ      = 3'd4,
    WRITE     = 3'd5,
    ABORT     = 3'd6
  } state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/memctrl_rr_arb.sv
// Two-way alternating arbiter between instruction fetch and data port.
// On contention the port that did not win last time is granted.
module memctrl_rr_arb
  import memctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_instr,
  input  logic   req_data,
  input  logic   grant_en,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  owner_t last_q;

  always_comb begin
    gnt_valid = req_instr | req_data;
    if (req_instr && req_data) begin
      gnt_owner = other_owner(last_q);
    end else if (req_data) begin
      gnt_owner = OWN_DATA;
    end else begin
      gnt_owner = OWN_INSTR;
    end
  end

  // Last-grant starts at instr so data wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_INSTR;
    end else if (grant_en && gnt_valid) begin
      last_q <= gnt_owner;
    end
  end

endmodule

// File: rtl/memctrl_arb.sv
// Fetch/data memory controller: one bus transaction at a time, alternating
// arbitration, optional bus timeout enabled by MEMCTRL_TIMEOUT_EN.
//
// state     | meaning
// INIT      | one cycle after reset
// IDLE      | waiting for a request, completion valid pulses here
// READ_REQ  | bus_re high until bus accepts (!bus_busy)
// WRITE_REQ | bus_we high until bus accepts (!bus_busy)
// READ      | waiting for bus_ack with read data
// WRITE     | waiting for bus_ack of a store
// ABORT     | timeout: valid + err pulse, rdata forced to 0
module memctrl_arb
  import memctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic                  bus_busy,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic                  bus_re,
  output logic                  bus_we,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic                  err,
  output logic [2:0]            state
);

  localparam int BE_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("memctrl_arb: DATA_W must be a multiple of 8 and TIMEOUT_CYC >= 1");
  end

  state_t state_q;
  owner_t owner_q;
  logic   req_instr;
  logic   req_data;
  logic   grant_en;
  logic   gnt_valid;
  owner_t gnt_owner;

  // A port whose valid pulse is still visible cannot be re-granted yet.
  assign req_instr = if_req & ~if_valid;
  assign req_data  = d_req & ~d_valid;
  assign grant_en  = (state_q == IDLE);
  assign state     = state_q;

  memctrl_rr_arb u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .req_instr (req_instr),
    .req_data  (req_data),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      owner_q   <= OWN_INSTR;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        INIT: state_q <= IDLE;
        IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_owner;
            if (gnt_owner == OWN_DATA) begin
              bus_addr  <= d_addr;
              bus_wdata <= d_wdata;
              bus_be    <= d_be;
              bus_we    <= d_we;
              bus_re    <= ~d_we;
              state_q   <= d_we ? WRITE_REQ : READ_REQ;
            end else begin
              bus_addr  <= if_addr;
              bus_wdata <= '0;
              bus_be    <= {BE_W{1'b1}};
              bus_we    <= 1'b0;
              bus_re    <= 1'b1;
              state_q   <= READ_REQ;
            end
          end
        end
        READ_REQ, WRITE_REQ: begin
          if (!bus_busy) begin
            bus_re  <= 1'b0;
            bus_we  <= 1'b0;
            state_q <= (state_q == READ_REQ) ? READ : WRITE;
`ifdef MEMCTRL_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        READ, WRITE: begin
          if (bus_ack) begin
            state_q <= IDLE;
            if (owner_q == OWN_DATA) begin
              d_valid <= 1'b1;
              if (state_q == READ) d_rdata <= bus_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= bus_rdata;
            end
          end
`ifdef MEMCTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= ABORT;
            err     <= 1'b1;
            if (owner_q == OWN_DATA) begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ABORT:   state_q <= IDLE;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_memctrl_arb.sv
// Self-checking bench for memctrl_arb: directed scenarios plus a randomized
// run checked against a transaction-level model of the controller.
module tb_memctrl_arb;
  import memctrl_pkg::*;

  localparam int TMO = 4;
  localparam logic [31:0] MAGIC = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, bus_busy, bus_ack;
  logic [31:0] if_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_be;
  logic [31:0] bus_addr, bus_wdata, if_rdata, d_rdata;
  logic [3:0]  bus_be;
  logic        bus_re, bus_we, if_valid, d_valid, err;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d = '0;

  always #5 clk = ~clk;

  memctrl_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_re(bus_re), .bus_we(bus_we),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a granted transaction, accept it, ack it once and drop the
  // finished requester's req on its valid pulse.
  task automatic serve(output logic [31:0] got_addr, output logic ok);
    int n = 0;
    ok = 1'b0;
    got_addr = '0;
    while (!(bus_re || bus_we) && n < 20) begin
      tick();
      n++;
    end
    if (!(bus_re || bus_we)) return;
    got_addr = bus_addr;
    bus_busy = 1'b0;
    tick();
    bus_ack = 1'b1;
    bus_rdata = got_addr ^ MAGIC;
    tick();
    bus_ack = 1'b0;
    ok = if_valid || d_valid;
    if (if_valid) if_req = 1'b0;
    if (d_valid) d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h40; d_wdata = '0; d_be = 4'h5;
    bus_busy = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) tick();
    checks++;
    if ({bus_addr, bus_wdata, bus_be, bus_re, bus_we, if_rdata, if_valid,
         d_rdata, d_valid, err, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d bus_re=%b bus_we=%b bus_addr=%h if_valid=%b d_valid=%b err=%b, want all zero",
               state, bus_re, bus_we, bus_addr, if_valid, d_valid, err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state !== IDLE) begin
      errors++; $display("FAIL reset_init_to_idle: state=%0d want %0d", state, IDLE);
    end
    tick();
    checks++;
    if (state !== READ_REQ || bus_re !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h40 || bus_be !== 4'h5) begin
      errors++;
      $display("FAIL reset_data_first: state=%0d re=%b we=%b addr=%h be=%h want state=2 re=1 we=0 addr=40 be=5",
               state, bus_re, bus_we, bus_addr, bus_be);
    end
    tick();
    checks++;
    if (state !== READ) begin
      errors++; $display("FAIL reset_read_accept: state=%0d want %0d", state, READ);
    end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'h1234_5678 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_load: d_valid=%b if_valid=%b d_rdata=%h err=%b want 1 0 12345678 0",
               d_valid, if_valid, d_rdata, err);
    end
    d_req = 1'b0; exp_d = 32'h1234_5678;
    tick();
    checks++;
    if (bus_re !== 1'b1 || bus_addr !== 32'h80 || bus_be !== 4'hF) begin
      errors++;
      $display("FAIL reset_instr_second: re=%b addr=%h be=%h want 1 80 f", bus_re, bus_addr, bus_be);
    end
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL reset_first_fetch: if_valid=%b if_rdata=%h want 1 cafef00d", if_valid, if_rdata);
    end
    if_req = 1'b0; exp_if = 32'hCAFE_F00D;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    checks++;
    if (state !== READ_REQ || bus_re !== 1'b1 || bus_addr !== 32'h100 || bus_be !== 4'hF) begin
      errors++;
      $display("FAIL fetch_grant: state=%0d re=%b addr=%h be=%h want 2 1 100 f", state, bus_re, bus_addr, bus_be);
    end
    tick();
    checks++;
    if (if_valid !== 1'b0 || bus_re !== 1'b0 || state !== READ) begin
      errors++;
      $display("FAIL fetch_read: if_valid=%b re=%b state=%0d want 0 0 4", if_valid, bus_re, state);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_complete: if_valid=%b if_rdata=%h d_valid=%b want 1 00500093 0", if_valid, if_rdata, d_valid);
    end
    if_req = 1'b0; exp_if = 32'h0050_0093;
    tick();
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== exp_if) begin
      errors++;
      $display("FAIL fetch_hold: if_valid=%b if_rdata=%h want 0 %h", if_valid, if_rdata, exp_if);
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    bus_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== WRITE_REQ || bus_we !== 1'b1 || bus_re !== 1'b0 || bus_addr !== 32'h2000 ||
          bus_wdata !== 32'hDEAD_BEEF || bus_be !== 4'b0011) begin
        errors++;
        $display("FAIL store_req_%0d: state=%0d we=%b re=%b addr=%h wdata=%h be=%b want 3 1 0 2000 deadbeef 0011",
                 i, state, bus_we, bus_re, bus_addr, bus_wdata, bus_be);
      end
      if (i == 3) bus_busy = 1'b0;
      tick();
    end
    checks++;
    if (state !== WRITE || bus_we !== 1'b0) begin
      errors++; $display("FAIL store_accept: state=%0d we=%b want 5 0", state, bus_we);
    end
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || d_rdata !== exp_d || err !== 1'b0) begin
      errors++;
      $display("FAIL store_complete: d_valid=%b d_rdata=%h err=%b want 1 %h 0", d_valid, d_rdata, err, exp_d);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    logic ok;
    logic exp_bit;
    // last grant was the store, so instr leads and the ports alternate
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0400; d_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_bit = (k % 2 == 1);
      serve(got, ok);
      checks++;
      if (!ok || got[31] !== exp_bit) begin
        errors++;
        $display("FAIL back_to_back_%0d: ok=%b data_owner=%b want ok=1 data_owner=%b", k, ok, got[31], exp_bit);
      end
      if (k < 3) begin
        if (!if_req) begin if_req = 1'b1; if_addr = 32'h400 + 32'(k * 4); end
        if (!d_req) begin d_req = 1'b1; d_addr = 32'h8000_0400 + 32'(k * 4); end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_last_grant();
    logic [31:0] got;
    logic ok;
    logic exp_seq [5];
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0; exp_seq[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0 || k == 3) begin
        if_req = 1'b1; if_addr = 32'h600; d_req = 1'b1; d_addr = 32'h8000_0600;
      end else if (k == 2) begin
        d_req = 1'b1; d_addr = 32'h8000_0700;
      end
      serve(got, ok);
      checks++;
      if (!ok || got[31] !== exp_seq[k]) begin
        errors++;
        $display("FAIL last_grant_%0d: ok=%b data_owner=%b want ok=1 data_owner=%b", k, ok, got[31], exp_seq[k]);
      end
      if (ok) begin
        if (got[31]) exp_d = got ^ MAGIC; else exp_if = got ^ MAGIC;
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; bus_busy = 1'b0; bus_ack = 1'b0;
    tick();
    tick();
`ifdef MEMCTRL_TIMEOUT_EN
    while (state == READ && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != TMO || state !== ABORT || err !== 1'b1 || d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_abort: read_cycles=%0d state=%0d err=%b d_valid=%b d_rdata=%h want %0d 6 1 1 0",
               n, state, err, d_valid, d_rdata, TMO);
    end
    d_req = 1'b0; exp_d = '0;
    tick();
    checks++;
    if (state !== IDLE || err !== 1'b0 || d_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: state=%0d err=%b d_valid=%b want 1 0 0", state, err, d_valid);
    end
    d_req = 1'b1; d_addr = 32'h3004;
    tick();
    tick();
    repeat (TMO - 1) tick();
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h0BAD_F00D || state !== IDLE) begin
      errors++;
      $display("FAIL timeout_ack_wins: d_valid=%b err=%b d_rdata=%h state=%0d want 1 0 0badf00d 1",
               d_valid, err, d_rdata, state);
    end
    d_req = 1'b0; exp_d = 32'h0BAD_F00D;
    tick();
`else
    repeat (30) tick();
    checks++;
    if (state !== READ || d_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL no_timeout_wait: state=%0d d_valid=%b err=%b want 4 0 0", state, d_valid, err);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (d_valid !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL no_timeout_late_ack: d_valid=%b err=%b d_rdata=%h want 1 0 0badf00d", d_valid, err, d_rdata);
    end
    d_req = 1'b0; exp_d = 32'h0BAD_F00D;
    tick();
`endif
  endtask

  task automatic test_reset_inflight();
    if_req = 1'b1; if_addr = 32'h500; bus_busy = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== READ) begin
      errors++; $display("FAIL inflight_setup: state=%0d want 4", state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (state !== INIT || bus_re !== 1'b0 || bus_we !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_reset: state=%0d re=%b we=%b if_valid=%b want 0 0 0 0", state, bus_re, bus_we, if_valid);
    end
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    tick();
    bus_ack = 1'b0; if_req = 1'b0;
    checks++;
    if (state !== IDLE || if_valid !== 1'b0 || d_valid !== 1'b0 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL inflight_late_ack: state=%0d if_valid=%b d_valid=%b if_rdata=%h want 1 0 0 0",
               state, if_valid, d_valid, if_rdata);
    end
    exp_if = '0; exp_d = '0;
    tick();
  endtask

  // Transaction-level model: each request is granted by the alternation
  // rule, carries the requester's fields to the bus, and completes with a
  // valid pulse the cycle after its ack.
  task automatic test_random();
    int     phase = 0;
    int     ack_cnt = 0;
    int     n_i = 0;
    int     n_d = 0;
    owner_t last = OWN_INSTR;
    owner_t cur = OWN_INSTR;
    owner_t want;
    logic   pi = 1'b0;
    logic   pd = 1'b0;
    logic   drop_i, drop_d, ok;
    logic [31:0] t_addr = '0;
    logic   t_we = 1'b0;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_be;
    logic   w_we;
    if_req = 1'b0; d_req = 1'b0; bus_busy = 1'b0; bus_ack = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      drop_i = 1'b0; drop_d = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = $urandom();
      checks++;
      if (phase == 3) begin
        if (cur == OWN_INSTR)
          ok = (if_valid === 1'b1) && (d_valid === 1'b0) && (err === 1'b0) && (if_rdata === (t_addr ^ MAGIC));
        else
          ok = (d_valid === 1'b1) && (if_valid === 1'b0) && (err === 1'b0) &&
               (d_rdata === (t_we ? exp_d : (t_addr ^ MAGIC)));
        if (!ok) begin
          errors++;
          $display("FAIL rand_complete c=%0d: owner=%0d if_valid=%b d_valid=%b err=%b if_rdata=%h d_rdata=%h addr=%h we=%b",
                   c, cur, if_valid, d_valid, err, if_rdata, d_rdata, t_addr, t_we);
        end
        if (cur == OWN_INSTR) begin
          exp_if = t_addr ^ MAGIC; if_req = 1'b0; drop_i = 1'b1;
        end else begin
          if (!t_we) exp_d = t_addr ^ MAGIC;
          d_req = 1'b0; drop_d = 1'b1;
        end
        phase = 0;
      end else if (if_valid !== 1'b0 || d_valid !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL rand_spurious c=%0d: if_valid=%b d_valid=%b err=%b want all 0", c, if_valid, d_valid, err);
      end
      if (phase == 0 && (bus_re || bus_we)) begin
        want = (pi && pd) ? ((last == OWN_INSTR) ? OWN_DATA : OWN_INSTR) : (pd ? OWN_DATA : OWN_INSTR);
        if (want == OWN_DATA) begin
          w_addr = d_addr; w_we = d_we; w_be = d_be; w_wdata = d_wdata;
        end else begin
          w_addr = if_addr; w_we = 1'b0; w_be = 4'hF; w_wdata = bus_wdata;
        end
        checks++;
        if (!(pi || pd) || bus_addr !== w_addr || bus_be !== w_be || bus_we !== w_we ||
            bus_re !== !w_we || bus_wdata !== w_wdata) begin
          errors++;
          $display("FAIL rand_grant c=%0d: reqs=%b%b addr=%h be=%h we=%b re=%b wdata=%h want addr=%h be=%h we=%b wdata=%h",
                   c, pi, pd, bus_addr, bus_be, bus_we, bus_re, bus_wdata, w_addr, w_be, w_we, w_wdata);
        end
        cur = want; last = want; t_addr = w_addr; t_we = w_we;
        if (want == OWN_DATA) n_d++; else n_i++;
        phase = 1;
      end
      if (phase == 2) begin
        bus_busy = 1'($urandom_range(0, 1));
        if (ack_cnt == 0) begin
          bus_ack = 1'b1; bus_rdata = t_addr ^ MAGIC; phase = 3;
        end else begin
          ack_cnt--;
        end
      end else if (phase == 1) begin
        bus_busy = ($urandom_range(0, 2) == 0);
        bus_ack = ($urandom_range(0, 3) == 0);
        if (!bus_busy) begin
          phase = 2; ack_cnt = $urandom_range(0, 2);
        end
      end else begin
        bus_busy = 1'($urandom_range(0, 1));
      end
      if (!if_req && !drop_i && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom() & 32'h7FFF_FFFC;
      end
      if (!d_req && !drop_d && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = $urandom() | 32'h8000_0000; d_we = 1'($urandom_range(0, 1));
        d_be = 4'($urandom_range(1, 15)); d_wdata = $urandom();
      end
      pi = if_req; pd = d_req;
    end
    checks++;
    if (n_i < 50 || n_d < 50) begin
      errors++;
      $display("FAIL rand_progress: fetch_grants=%0d data_grants=%0d want >= 50 each", n_i, n_d);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_last_grant();
    test_timeout();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
